kcpsmx_scratch_arbiter: RTL and testbench

- Sits between the pipelined KCPSMX core, a host/debug port and the 64x8 scratchpad RAM.
- Muxes one access per cycle onto the RAM. The core has priority; the host uses a req/ack handshake.
- A wait counter bounds host starvation by stalling the core.
- Optional post-reset sweep zeroes the RAM.

---
 rtl/kcpsmx_scratch_arbiter_pkg.sv | 16 +
 rtl/kcpsmx_scratch.sv | 22 ++
 rtl/kcpsmx_scratch_arbiter.sv | 124 ++++++++++++
 tb/tb_kcpsmx_scratch_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx_scratch_arbiter_pkg.sv
// Shared scratchpad geometry and arbiter state encoding for the KCPSMX core slice.
package kcpsmx3_inc;

    localparam int SCRATCH_DEPTH = 6;
    localparam int SCRATCH_WIDTH = 8;
    localparam int SCRATCH_SIZE  = 64;

    typedef enum logic [1:0] {
        ARB_CLEAR,
        ARB_IDLE,
        ARB_ACK
    } scratch_arb_state_t;

    localparam int SCRATCH_ARB_MAX_WAIT = 4;

endpackage

// File: rtl/kcpsmx_scratch.sv
// 64x8 scratchpad RAM: synchronous write, asynchronous read.
module kcpsmx_scratch
    import kcpsmx3_inc::*;
(
    input  logic                     clk,
    input  logic [SCRATCH_DEPTH-1:0] address,
    input  logic                     write_enable,
    input  logic [SCRATCH_WIDTH-1:0] data_in,
    output logic [SCRATCH_WIDTH-1:0] data_out
);

    logic [SCRATCH_WIDTH-1:0] r_mem [SCRATCH_SIZE];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            r_mem[address] <= data_in;
        end
    end

    assign data_out = r_mem[address];

endmodule

// File: rtl/kcpsmx_scratch_arbiter.sv
// Core/host arbiter in front of the scratchpad RAM with bounded host starvation.
// Define SCRATCH_CLEAR_EN to zero the RAM with a 64-cycle sweep after every reset.
module kcpsmx_scratch_arbiter
    import kcpsmx3_inc::*;
#(
    parameter int MAX_WAIT = SCRATCH_ARB_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_req,
    input  logic                     core_we,
    input  logic [SCRATCH_DEPTH-1:0] core_addr,
    input  logic [SCRATCH_WIDTH-1:0] core_wdata,
    output logic [SCRATCH_WIDTH-1:0] core_rdata,
    output logic                     core_stall,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [SCRATCH_DEPTH-1:0] host_addr,
    input  logic [SCRATCH_WIDTH-1:0] host_wdata,
    output logic                     host_ack,
    output logic [SCRATCH_WIDTH-1:0] host_rdata,
    output logic                     busy,
    output logic [SCRATCH_DEPTH-1:0] ram_addr,
    output logic                     ram_we,
    output logic [SCRATCH_WIDTH-1:0] ram_wdata,
    input  logic [SCRATCH_WIDTH-1:0] ram_rdata
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    scratch_arb_state_t       r_state;
    scratch_arb_state_t       w_state_nxt;
    logic [7:0]               r_wait_cnt;
    logic                     r_host_ack;
    logic [SCRATCH_WIDTH-1:0] r_host_rdata;
    logic                     w_force;
    logic                     w_grant_host;
`ifdef SCRATCH_CLEAR_EN
    localparam logic [SCRATCH_DEPTH-1:0] LP_CLR_LAST = SCRATCH_DEPTH'(SCRATCH_SIZE - 1);
    logic [SCRATCH_DEPTH-1:0] r_clr_cnt;
`endif

    assign core_rdata = ram_rdata;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_force      = 1'b0;
        w_grant_host = 1'b0;
        core_stall   = 1'b0;
        busy         = 1'b0;
        ram_addr     = core_addr;
        ram_wdata    = core_wdata;
        ram_we       = 1'b0;
        case (r_state)
`ifdef SCRATCH_CLEAR_EN
            ARB_CLEAR: begin
                busy       = 1'b1;
                core_stall = 1'b1;
                ram_addr   = r_clr_cnt;
                ram_wdata  = '0;
                ram_we     = 1'b1;
                if (r_clr_cnt == LP_CLR_LAST) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
`endif
            ARB_IDLE: begin
                // Stall is derived from host side only so the core can never loop through it.
                w_force      = host_req && (r_wait_cnt == LP_MAX_WAIT);
                w_grant_host = host_req && (!core_req || w_force);
                core_stall   = w_force;
                if (w_grant_host) begin
                    ram_addr    = host_addr;
                    ram_wdata   = host_wdata;
                    ram_we      = host_we;
                    w_state_nxt = ARB_ACK;
                end else begin
                    ram_we = core_req && core_we;
                end
            end
            ARB_ACK: begin
                ram_we      = core_req && core_we;
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef SCRATCH_CLEAR_EN
            r_state   <= ARB_CLEAR;
            r_clr_cnt <= '0;
`else
            r_state   <= ARB_IDLE;
`endif
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_host_ack <= w_grant_host;
            if (w_grant_host) begin
                r_host_rdata <= ram_rdata;
            end
`ifdef SCRATCH_CLEAR_EN
            if (r_state == ARB_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
`endif
            // Count only cycles the host actually lost to the core.
            if (w_grant_host || !host_req || r_state == ARB_CLEAR) begin
                r_wait_cnt <= '0;
            end else if (r_state == ARB_IDLE && core_req && r_wait_cnt != LP_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kcpsmx_scratch_arbiter.sv
// Self-checking bench: arbiter plus scratch RAM against a per-cycle behavioural model.
module tb_kcpsmx_scratch_arbiter;
    import kcpsmx3_inc::*;

    localparam int MAX_WAIT = 4;
`ifdef SCRATCH_CLEAR_EN
    localparam int CLR_CYCLES = 64;
`else
    localparam int CLR_CYCLES = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we;
    logic [5:0] core_addr;
    logic [7:0] core_wdata, core_rdata;
    logic       core_stall;
    logic       host_req, host_we;
    logic [5:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic       host_ack, busy;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    kcpsmx_scratch_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    kcpsmx_scratch u_ram (
        .clk(clk), .address(ram_addr), .write_enable(ram_we),
        .data_in(ram_wdata), .data_out(ram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: memory image plus host-transaction bookkeeping.
    logic [7:0] m_mem [64];
    bit         m_val [64];
    bit         m_known = 0;
    int         m_clear_left = 0;
    int         m_losses = 0;
    bit         m_ack = 0;
    bit         m_in_ack = 0;
    logic [7:0] m_hrd = 8'h00;
    bit         m_hrd_val = 0;

    always @(negedge clk) begin
        bit         wins, forced, e_we, e_stall, e_busy, was_ack;
        logic [5:0] e_addr;
        logic [7:0] e_wd;
        int         slot;
        if (m_known) begin
            wins = 0; forced = 0;
            if (m_clear_left > 0) begin
                e_busy = 1; e_stall = 1; e_we = 1;
                slot = 64 - m_clear_left;
                e_addr = slot[5:0]; e_wd = 8'h00;
            end else begin
                e_busy = 0;
                if (!m_in_ack) begin
                    forced = host_req && (m_losses == MAX_WAIT);
                    wins   = host_req && (!core_req || forced);
                end
                e_stall = forced;
                if (wins) begin
                    e_addr = host_addr; e_wd = host_wdata; e_we = host_we;
                end else begin
                    e_addr = core_addr; e_wd = core_wdata; e_we = core_req && core_we && !forced;
                end
            end
            chk("model_busy", 32'(busy), 32'(e_busy));
            chk("model_stall", 32'(core_stall), 32'(e_stall));
            chk("model_ram_we", 32'(ram_we), 32'(e_we));
            chk("model_ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("model_ram_wdata", 32'(ram_wdata), 32'(e_wd));
            chk("model_host_ack", 32'(host_ack), 32'(m_ack));
            if (m_hrd_val) chk("model_host_rdata", 32'(host_rdata), 32'(m_hrd));
            if (m_val[e_addr]) chk("model_core_rdata", 32'(core_rdata), 32'(m_mem[e_addr]));

            was_ack = m_in_ack;
            if (wins) begin
                m_hrd = m_mem[host_addr]; m_hrd_val = m_val[host_addr];
            end
            if (e_we) begin
                m_mem[e_addr] = e_wd; m_val[e_addr] = 1;
            end
            m_ack = wins; m_in_ack = wins;
            if (m_clear_left > 0) begin
                m_clear_left--; m_losses = 0;
            end else if (!host_req || wins) begin
                m_losses = 0;
            end else if (!was_ack && core_req && m_losses < MAX_WAIT) begin
                m_losses++;
            end
        end
        if (reset) begin
            m_known = 1; m_ack = 0; m_in_ack = 0; m_losses = 0;
            m_hrd = 8'h00; m_hrd_val = 1; m_clear_left = CLR_CYCLES;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_xfer(input logic we, input logic [5:0] a, input logic [7:0] d,
                             output logic [7:0] rd, output int lat);
        host_req = 1; host_we = we; host_addr = a; host_wdata = d; lat = 0;
        do begin
            tick();
            lat++;
        end while (!host_ack && lat < 200);
        if (!host_ack) chk("host_ack_timeout", 0, 1);
        rd = host_rdata;
        host_req = 0; host_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int lat, n;
        reset = 1; core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        tick(); tick();
        reset = 0;

        // Reset state and clear sweep length
        chk("rst_host_ack", 32'(host_ack), 0);
        chk("rst_host_rdata", 32'(host_rdata), 0);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("clear_cycles", n, CLR_CYCLES);
`ifdef SCRATCH_CLEAR_EN
        host_xfer(1'b0, 6'h2A, 8'h00, rd, lat);
        chk("clear_read_2A", 32'(rd), 32'h00);
        chk("clear_read_lat", lat, 1);
`endif

        // Core only: write then read-back in the following cycle
        core_req = 1; core_we = 1; core_addr = 6'h15; core_wdata = 8'hA5;
        tick();
        core_we = 0;
        #2;
        chk("core_rdata_15", 32'(core_rdata), 32'hA5);
        chk("core_stall_free", 32'(core_stall), 0);
        chk("core_no_ack", 32'(host_ack), 0);
        tick();
        core_req = 0;

        // Host only: write then read
        host_xfer(1'b1, 6'h3F, 8'h5C, rd, lat);
        chk("host_wr_lat", lat, 1);
        tick();
        chk("host_ack_pulse", 32'(host_ack), 0);
        host_xfer(1'b0, 6'h3F, 8'h00, rd, lat);
        chk("host_rd_3F", 32'(rd), 32'h5C);
        chk("host_rd_lat", lat, 1);
        tick();

        // Starvation: host wins on the 5th contended cycle, twice in a row
        for (int r = 0; r < 2; r++) begin
            core_req = 1; core_we = 0; core_addr = 6'h15;
            host_req = 1; host_we = (r == 0); host_addr = 6'h10; host_wdata = 8'h77;
            for (int i = 0; i <= MAX_WAIT; i++) begin
                #2;
                chk("starve_stall", 32'(core_stall), 32'(i == MAX_WAIT));
                tick();
            end
            chk("starve_ack", 32'(host_ack), 1);
            if (r == 1) chk("starve_rdata", 32'(host_rdata), 32'h77);
            host_req = 0;
            #2;
            chk("ack_cycle_stall", 32'(core_stall), 0);
            tick();
        end
        core_req = 0;

        // Back-to-back host requests
        host_req = 1; host_we = 1; host_addr = 6'h20; host_wdata = 8'h11;
        tick();
        chk("b2b_ack1", 32'(host_ack), 1);
        host_addr = 6'h21; host_wdata = 8'h22;
        #2;
        chk("b2b_no_grant_in_ack", 32'(ram_we), 0);
        tick();
        chk("b2b_gap", 32'(host_ack), 0);
        #2;
        chk("b2b_grant2_addr", 32'(ram_addr), 32'h21);
        tick();
        chk("b2b_ack2", 32'(host_ack), 1);
        host_req = 0; host_we = 0;
        core_req = 1; core_addr = 6'h20;
        #2;
        chk("b2b_mem20", 32'(core_rdata), 32'h11);
        tick();
        core_addr = 6'h21;
        #2;
        chk("b2b_mem21", 32'(core_rdata), 32'h22);
        tick();
        core_req = 0;

        // Reset lands on the ack edge; request is re-served afterwards
        host_req = 1; host_we = 0; host_addr = 6'h3F; reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_ack", 32'(host_ack), 0);
        chk("rst_mid_rdata", 32'(host_rdata), 0);
        lat = 0;
        while (!host_ack && lat < 200) begin
            tick();
            lat++;
        end
        chk("rst_reserve_lat", lat, CLR_CYCLES + 1);
`ifdef SCRATCH_CLEAR_EN
        chk("rst_reserve_rdata", 32'(host_rdata), 32'h00);
`else
        chk("rst_reserve_rdata", 32'(host_rdata), 32'h5C);
`endif
        host_req = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
